// File: rtl/ppe_pkg.sv
// Shared definitions for the round-robin programmable-priority arbiter.
//   ppe_state_e   : output-stage state (EMPTY = no grant held, FULL = grant held)
//   idx_wrap_inc  : index + 1, wrapping to 0 past the last requester
package ppe_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ppe_state_e;

    function automatic logic [31:0] idx_wrap_inc(input logic [31:0] idx,
                                                 input int unsigned width);
        return (idx == width - 1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/ppe_wrap_search.sv
// Wrapping priority search: lowest set request at or above ptr, else lowest set
// request overall.
//   Req    : request vector
//   ptr    : priority pointer (values >= WIDTH mask everything, so the
//            unmasked half takes over)
//   win_oh : one-hot winner, zero when nothing requests
//   win_idx: binary index of win_oh
//   found  : any request set
module ppe_wrap_search #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned LOG_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] Req,
    input  logic [LOG_W-1:0] ptr,
    output logic [WIDTH-1:0] win_oh,
    output logic [LOG_W-1:0] win_idx,
    output logic             found
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] masked_req;
    logic [WIDTH-1:0] masked_oh;
    logic [WIDTH-1:0] unmasked_oh;

    // Thermometer mask: bit i set when i >= ptr.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            mask[i] = (i >= 32'(ptr));
        end
    end

    assign masked_req = Req & mask;

    // x & -x isolates the lowest set bit.
    assign masked_oh   = masked_req & (~masked_req + WIDTH'(1));
    assign unmasked_oh = Req & (~Req + WIDTH'(1));

    assign found  = |Req;
    assign win_oh = (|masked_req) ? masked_oh : unmasked_oh;

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (win_oh[i]) begin
                win_idx = win_idx | LOG_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_ppe_arbiter.sv
// Registered round-robin arbiter with a valid/ready grant stage.
//   clk, rst_n        : clock, synchronous active-low reset
//   Req               : request vector
//   Gnt, gnt_idx      : registered one-hot grant and its index (zero when idle)
//   gnt_valid         : grant held in the output register
//   gnt_ready         : consumer accepts the held grant
//   lock              : on accept, keep the accepted index at top priority
//   prio_load,prio_val: overwrite the priority pointer (out-of-range loads 0)
module rr_ppe_arbiter
    import ppe_pkg::*;
#(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned LOG_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Req,
    output logic [WIDTH-1:0] Gnt,
    output logic [LOG_W-1:0] gnt_idx,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    input  logic             lock,
    input  logic             prio_load,
    input  logic [LOG_W-1:0] prio_val
);

    ppe_state_e       state_q;
    logic [LOG_W-1:0] ptr_q;
    logic [LOG_W-1:0] ptr_d;
    logic [WIDTH-1:0] gnt_q;
    logic [LOG_W-1:0] idx_q;

    logic             accept;
    logic [WIDTH-1:0] win_oh;
    logic [LOG_W-1:0] win_idx;
    logic             found;

    assign accept = (state_q == FULL) && gnt_ready;

    // Next pointer feeds the search directly so a reload after accept is
    // already fair in the same cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = lock ? idx_q : LOG_W'(idx_wrap_inc(32'(idx_q), WIDTH));
        end
        if (prio_load) begin
            ptr_d = (32'(prio_val) >= WIDTH) ? '0 : prio_val;
        end
    end

    ppe_wrap_search #(
        .WIDTH(WIDTH),
        .LOG_W(LOG_W)
    ) u_search (
        .Req    (Req),
        .ptr    (ptr_d),
        .win_oh (win_oh),
        .win_idx(win_idx),
        .found  (found)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            unique case (state_q)
                EMPTY: begin
                    if (found) begin
                        state_q <= FULL;
                        gnt_q   <= win_oh;
                        idx_q   <= win_idx;
                    end
                end
                FULL: begin
                    // Held grant is frozen until accepted.
                    if (gnt_ready) begin
                        if (found) begin
                            gnt_q <= win_oh;
                            idx_q <= win_idx;
                        end else begin
                            state_q <= EMPTY;
                            gnt_q   <= '0;
                            idx_q   <= '0;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign Gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == FULL);

endmodule
